// File: rtl/csa_pkg.sv
// Shared types and helpers for the pipelined conditional-sum subtractor.
// LEVELS is always derived from the operand width through csa_levels().
package csa_pkg;

  localparam int CSA_W_DEFAULT = 8;

  // One resolved {sum, carry} variant at the default operand width.
  typedef struct packed {
    logic [CSA_W_DEFAULT-1:0] sum;
    logic                     carry;
  } csa_pair_t;

  function automatic int csa_levels(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/conditional_sum_subtractor_pipe_if.sv
// Handshaked operand/result bundle for conditional_sum_subtractor_pipe.
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// A producer holds valid and its payload stable until that edge. Ready may depend
// combinationally on the consumer's own state, but never on the producer's valid.
interface conditional_sum_subtractor_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, x, y, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, x, y, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/csa_group_mux.sv
// 2:1 select of a {group_sum, group_carry} variant, driven by the carry
// of the group immediately below it.
module csa_group_mux #(
  parameter int GW = 1
) (
  input  logic          sel_i,
  input  logic [GW-1:0] a_sum_i,
  input  logic          a_carry_i,
  input  logic [GW-1:0] b_sum_i,
  input  logic          b_carry_i,
  output logic [GW-1:0] y_sum_o,
  output logic          y_carry_o
);

  assign y_sum_o   = sel_i ? b_sum_i   : a_sum_i;
  assign y_carry_o = sel_i ? b_carry_i : a_carry_i;

endmodule

// File: rtl/conditional_sum_subtractor_pipe.sv
// Pipelined conditional-sum subtractor: diff = x + ~y + ~bin, with one register
// bank after every merge level, so it produces a result LEVELS cycles after acceptance.
module conditional_sum_subtractor_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_W_DEFAULT
) (
  input logic                              clk,
  input logic                              rst,
  conditional_sum_subtractor_pipe_if.slave bus
);

  localparam int LEVELS = csa_levels(WIDTH);

  logic             adv;
  logic [WIDTH-1:0] y_n;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             cin;

  assign y_n = ~bus.y;
  assign p   = bus.x ^ y_n;
  assign g   = bus.x & y_n;
  assign cin = ~bus.bin;

  // Level k splits the word into a resolved low group of 2^k bits (r_s/r_c)
  // and the remaining groups, each kept in both cin=0 (vs0/vc0) and cin=1
  // (vs1/vc1) variants. Level 0 is combinational; levels 1..LEVELS are registered.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int G = 1 << k;

    logic [G-1:0] r_s;
    logic         r_c;
    logic         v;

    if (k == 0) begin : g_res
      assign v   = bus.in_valid;
      assign r_s = p[0] ^ cin;
      assign r_c = g[0] | (p[0] & cin);
    end else begin : g_res
      localparam int H = G >> 1;

      logic [G-1:0] r_s_d;
      logic         r_c_d;
      logic [H-1:0] hi_s;

      // The bit-0 group is already resolved, so it selects once on its true carry.
      csa_group_mux #(.GW(H)) u_mux (
        .sel_i    (g_lvl[k-1].r_c),
        .a_sum_i  (g_lvl[k-1].g_var.vs0[H-1:0]),
        .a_carry_i(g_lvl[k-1].g_var.vc0[0]),
        .b_sum_i  (g_lvl[k-1].g_var.vs1[H-1:0]),
        .b_carry_i(g_lvl[k-1].g_var.vc1[0]),
        .y_sum_o  (hi_s),
        .y_carry_o(r_c_d)
      );

      assign r_s_d = {hi_s, g_lvl[k-1].r_s};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v   <= 1'b0;
          r_s <= '0;
          r_c <= 1'b0;
        end else if (adv) begin
          v   <= g_lvl[k-1].v;
          r_s <= r_s_d;
          r_c <= r_c_d;
        end
      end

      if (k == LEVELS) begin : g_last
        logic cmsb;

        // Carry into the MSB recovered from its resolved sum bit and its propagate.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cmsb <= 1'b0;
          end else if (adv) begin
            cmsb <= r_s_d[WIDTH-1] ^ g_lvl[k-1].g_var.p_m;
          end
        end
      end
    end

    if (k < LEVELS) begin : g_var
      localparam int NG = WIDTH >> k;

      logic [WIDTH-G-1:0] vs0;
      logic [WIDTH-G-1:0] vs1;
      logic [NG-2:0]      vc0;
      logic [NG-2:0]      vc1;
      logic               p_m;

      if (k == 0) begin : g_gen
        assign vs0 = p[WIDTH-1:1];
        assign vs1 = ~p[WIDTH-1:1];
        assign vc0 = g[WIDTH-1:1];
        assign vc1 = g[WIDTH-1:1] | p[WIDTH-1:1];
        assign p_m = p[WIDTH-1];
      end else begin : g_gen
        localparam int H = G >> 1;

        logic [WIDTH-G-1:0] vs0_d;
        logic [WIDTH-G-1:0] vs1_d;
        logic [NG-2:0]      vc0_d;
        logic [NG-2:0]      vc1_d;

        // New group j merges old lower group 2j and old upper group 2j+1;
        // old group i sits at local offset (i-1)*H after the resolved group.
        for (genvar j = 1; j < NG; j++) begin : g_grp
          logic [H-1:0] hi0;
          logic [H-1:0] hi1;
          logic         c0;
          logic         c1;

          csa_group_mux #(.GW(H)) u_m0 (
            .sel_i    (g_lvl[k-1].g_var.vc0[2*j-1]),
            .a_sum_i  (g_lvl[k-1].g_var.vs0[2*j*H +: H]),
            .a_carry_i(g_lvl[k-1].g_var.vc0[2*j]),
            .b_sum_i  (g_lvl[k-1].g_var.vs1[2*j*H +: H]),
            .b_carry_i(g_lvl[k-1].g_var.vc1[2*j]),
            .y_sum_o  (hi0),
            .y_carry_o(c0)
          );

          csa_group_mux #(.GW(H)) u_m1 (
            .sel_i    (g_lvl[k-1].g_var.vc1[2*j-1]),
            .a_sum_i  (g_lvl[k-1].g_var.vs0[2*j*H +: H]),
            .a_carry_i(g_lvl[k-1].g_var.vc0[2*j]),
            .b_sum_i  (g_lvl[k-1].g_var.vs1[2*j*H +: H]),
            .b_carry_i(g_lvl[k-1].g_var.vc1[2*j]),
            .y_sum_o  (hi1),
            .y_carry_o(c1)
          );

          assign vs0_d[(j-1)*G +: G] = {hi0, g_lvl[k-1].g_var.vs0[(2*j-1)*H +: H]};
          assign vs1_d[(j-1)*G +: G] = {hi1, g_lvl[k-1].g_var.vs1[(2*j-1)*H +: H]};
          assign vc0_d[j-1]          = c0;
          assign vc1_d[j-1]          = c1;
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            vs0 <= '0;
            vs1 <= '0;
            vc0 <= '0;
            vc1 <= '0;
            p_m <= 1'b0;
          end else if (adv) begin
            vs0 <= vs0_d;
            vs1 <= vs1_d;
            vc0 <= vc0_d;
            vc1 <= vc1_d;
            p_m <= g_lvl[k-1].g_var.p_m;
          end
        end
      end
    end
  end

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = g_lvl[LEVELS].v;
  assign bus.diff      = g_lvl[LEVELS].r_s;
  // Borrow is qualified by valid so an empty output stage reads as zero.
  assign bus.bout      = g_lvl[LEVELS].v & ~g_lvl[LEVELS].r_c;
  assign bus.ovf       = g_lvl[LEVELS].g_res.g_last.cmsb ^ g_lvl[LEVELS].r_c;

endmodule

// File: tb/tb_conditional_sum_subtractor_pipe.sv
// Bench for conditional_sum_subtractor_pipe: directed vectors, stall and reset
// scenarios, and a broad sweep, checked through an expected-result queue.
module tb_conditional_sum_subtractor_pipe;
  import csa_pkg::*;

  localparam int W   = CSA_W_DEFAULT;
  localparam int LAT = csa_levels(W);
  localparam int RW  = W + 2;

  typedef struct packed {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          bin;
    logic [RW-1:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  conditional_sum_subtractor_pipe_if #(.WIDTH(W)) bus ();

  conditional_sum_subtractor_pipe #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  vec_t          stim_q[$];
  logic [RW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Result packed as {ovf, bout, diff}.
  function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic b);
    logic [W:0] r;
    int         sr;
    logic       o;
    r  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, b};
    sr = int'($signed(x)) - int'($signed(y)) - int'(b);
    o  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    return {o, r[W], r[W-1:0]};
  endfunction

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic b,
                              input logic [RW-1:0] res);
    vec_t v;
    v.x   = x;
    v.y   = y;
    v.bin = b;
    v.res = res;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Inputs change 1ns after the rising edge; acceptance is judged at the falling edge.
  task automatic cycle(input logic ordy);
    @(posedge clk);
    #1;
    bus.out_ready = ordy;
    if (stim_q.size() != 0) begin
      bus.in_valid = 1'b1;
      bus.x        = stim_q[0].x;
      bus.y        = stim_q[0].y;
      bus.bin      = stim_q[0].bin;
    end else begin
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      exp_q.push_back(stim_q[0].res);
      void'(stim_q.pop_front());
    end
  endtask

  task automatic drain(input int budget, input logic random_stall);
    int n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle(random_stall ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d inputs and %0d results outstanding, required 0",
               stim_q.size(), exp_q.size());
      stim_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic measure(input vec_t v, input string name);
    int lat = 0;
    stim_q.push_back(v);
    while (stim_q.size() != 0 && lat < 20) begin
      cycle(1'b1);
      lat++;
    end
    lat = 0;
    do begin
      cycle(1'b1);
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 20);
    check(name, lat, LAT);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h, required no output",
                 {bus.ovf, bus.bout, bus.diff});
      end else begin
        check("result", {bus.ovf, bus.bout, bus.diff}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] xs[$];
    logic [W-1:0] xv;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_diff", bus.diff, 0);
    check("reset_bout", bus.bout, 0);
    check("reset_ovf", bus.ovf, 0);
    check("reset_in_ready", bus.in_ready, 1);

    // Latency and a plain subtraction.
    measure(mk(8'h50, 8'h30, 1'b0, {1'b0, 1'b0, 8'h20}), "latency_first");

    // Borrow, overflow and boundary vectors back to back.
    stim_q.push_back(mk(8'h00, 8'h01, 1'b0, {1'b0, 1'b1, 8'hFF}));
    stim_q.push_back(mk(8'h00, 8'h00, 1'b1, {1'b0, 1'b1, 8'hFF}));
    stim_q.push_back(mk(8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F}));
    stim_q.push_back(mk(8'h7F, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h80}));
    stim_q.push_back(mk(8'h5A, 8'h5A, 1'b0, {1'b0, 1'b0, 8'h00}));
    stim_q.push_back(mk(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF}));
    stim_q.push_back(mk(8'hFF, 8'h00, 1'b0, {1'b0, 1'b0, 8'hFF}));
    stim_q.push_back(mk(8'h00, 8'hFF, 1'b0, {1'b0, 1'b1, 8'h01}));
    stim_q.push_back(mk(8'h7F, 8'h80, 1'b1, {1'b1, 1'b1, 8'hFE}));
    stim_q.push_back(mk(8'h80, 8'h7F, 1'b0, {1'b1, 1'b0, 8'h01}));
    drain(100, 1'b0);

    // Five-deep stream with the output stalled on cycles 4..7.
    stim_q.push_back(mk(8'h10, 8'h01, 1'b0, {1'b0, 1'b0, 8'h0F}));
    stim_q.push_back(mk(8'h20, 8'h02, 1'b0, {1'b0, 1'b0, 8'h1E}));
    stim_q.push_back(mk(8'h30, 8'h03, 1'b1, {1'b0, 1'b0, 8'h2C}));
    stim_q.push_back(mk(8'h40, 8'h41, 1'b0, {1'b0, 1'b1, 8'hFF}));
    stim_q.push_back(mk(8'h05, 8'h05, 1'b1, {1'b0, 1'b1, 8'hFF}));
    for (int c = 1; c <= 8; c++) begin
      cycle(!(c >= 4 && c <= 7));
      if (c == 4) check("stall_out_valid", bus.out_valid, 1);
      if (c >= 4 && c <= 7 && bus.out_valid === 1'b1 && exp_q.size() != 0) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_hold", {bus.ovf, bus.bout, bus.diff}, exp_q[0]);
      end
    end
    drain(100, 1'b0);

    // Asynchronous reset with three results in flight.
    stim_q.push_back(mk(8'h11, 8'h22, 1'b0, {1'b0, 1'b1, 8'hEF}));
    stim_q.push_back(mk(8'h33, 8'h11, 1'b0, {1'b0, 1'b0, 8'h22}));
    stim_q.push_back(mk(8'h44, 8'h04, 1'b1, {1'b0, 1'b0, 8'h3F}));
    repeat (3) cycle(1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("pre_rst_out_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_diff", bus.diff, 0);
    exp_q.delete();
    stim_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    measure(mk(8'h9C, 8'h1C, 1'b0, {1'b0, 1'b0, 8'h80}), "latency_after_rst");

    // Sweep: every y and bin against a spread of x values, randomly stalled.
    for (int i = 0; i < 16; i++) begin
      xv = 8'(i * 17);
      xs.push_back(xv);
    end
    xs.push_back(8'h01);
    xs.push_back(8'h7F);
    xs.push_back(8'h80);
    xs.push_back(8'hFE);
    foreach (xs[i]) begin
      for (int yy = 0; yy < 256; yy++) begin
        for (int b = 0; b < 2; b++) begin
          stim_q.push_back(mk(xs[i], 8'(yy), 1'(b), model(xs[i], 8'(yy), 1'(b))));
        end
      end
    end
    drain(40000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
